// File: rtl/accumulation_buffer_ctrl_pkg.sv
// accumulation_buffer_ctrl_pkg: FSM state encodings and RMW latency shared by the accumulation buffer sequencer
package accumulation_buffer_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, WAIT_SWITCH} acc_state_t;
    typedef enum logic {WB_IDLE, WB_DRAIN} wb_state_t;
    localparam int ACC_RMW_LATENCY = 1;
endpackage

// File: rtl/accumulation_buffer_wb_drain.sv
// accumulation_buffer_wb_drain: streams one tile out of the writeback bank to a valid/ready consumer
module accumulation_buffer_wb_drain
    import accumulation_buffer_ctrl_pkg::*;
#(
    parameter int BANK_ADDR_WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [BANK_ADDR_WIDTH-1:0] ofmap_size,
    input  logic                       wb_ready,
    output logic                       ren_wb,
    output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
    output logic                       wb_valid,
    output logic                       wb_done
);
    wb_state_t                  state;
    logic [BANK_ADDR_WIDTH-1:0] wb_adr;
    logic                       issued;
    logic                       last_hs;
    // a new read is only issued when the output slot is empty or being emptied this cycle
    assign ren_wb  = state == WB_DRAIN && !issued && (!wb_valid || wb_ready);
    assign radr_wb = ren_wb ? wb_adr : '0;
    assign last_hs = state == WB_DRAIN && issued && wb_valid && wb_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WB_IDLE;
            wb_adr   <= '0;
            issued   <= 1'b0;
            wb_valid <= 1'b0;
            wb_done  <= 1'b1;
        end else if (start) begin
            state    <= WB_DRAIN;
            wb_adr   <= '0;
            issued   <= 1'b0;
            wb_valid <= 1'b0;
            wb_done  <= 1'b0;
        end else begin
            if (ren_wb) begin
                wb_adr <= wb_adr + 1'b1;
                issued <= wb_adr == ofmap_size - 1'b1;
            end
            wb_valid <= ren_wb || (wb_valid && !wb_ready);
            if (last_hs) begin
                state   <= WB_IDLE;
                wb_done <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/accumulation_buffer_ctrl.sv
// accumulation_buffer_ctrl: RMW address sequencer, writeback drain and bank switch for the double-banked accumulation buffer
// Optional stall counters are enabled with ACCUM_BUF_CTRL_PERF_EN.
module accumulation_buffer_ctrl
    import accumulation_buffer_ctrl_pkg::*;
#(
    parameter int BANK_ADDR_WIDTH = 9,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       config_en,
    input  logic [BANK_ADDR_WIDTH-1:0] config_ofmap_size,
    input  logic [COUNT_WIDTH-1:0]     config_num_passes,
    input  logic                       acc_valid,
    output logic                       acc_ready,
    output logic                       acc_first,
    output logic                       ren,
    output logic [BANK_ADDR_WIDTH-1:0] radr,
    output logic                       wen,
    output logic [BANK_ADDR_WIDTH-1:0] wadr,
    output logic                       ren_wb,
    output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic                       switch_banks,
    output logic                       tile_done
`ifdef ACCUM_BUF_CTRL_PERF_EN
    ,
    output logic [31:0]                stall_switch_cycles,
    output logic [31:0]                stall_wb_cycles
`endif
);
    acc_state_t                 state;
    logic [BANK_ADDR_WIDTH-1:0] n_cfg, adr;
    logic [COUNT_WIDTH-1:0]     p_cfg, pass;
    logic                       beat, last_word, wb_done;
    assign acc_ready    = state == ACCUM;
    assign beat         = acc_valid && acc_ready;
    assign ren          = beat;
    assign radr         = beat ? adr : '0;
    assign last_word    = adr == n_cfg - 1'b1;
    assign switch_banks = state == WAIT_SWITCH && wb_done;
    assign tile_done    = switch_banks;
    // the write stage trails the read by one register, giving the fixed RMW latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_cfg     <= '0;
            p_cfg     <= '0;
            adr       <= '0;
            pass      <= '0;
            wen       <= 1'b0;
            wadr      <= '0;
            acc_first <= 1'b0;
        end else begin
            wen       <= beat;
            acc_first <= beat && pass == '0;
            if (beat) wadr <= adr;
            case (state)
                IDLE: if (config_en) begin
                    n_cfg <= config_ofmap_size;
                    p_cfg <= config_num_passes;
                    state <= ACCUM;
                end
                ACCUM: if (beat) begin
                    adr  <= last_word ? '0 : adr + 1'b1;
                    pass <= last_word ? pass + 1'b1 : pass;
                    if (last_word && pass == p_cfg - 1'b1) state <= WAIT_SWITCH;
                end
                WAIT_SWITCH: if (wb_done) begin
                    adr   <= '0;
                    pass  <= '0;
                    state <= ACCUM;
                end
                default: state <= IDLE;
            endcase
        end
    end
    accumulation_buffer_wb_drain #(.BANK_ADDR_WIDTH(BANK_ADDR_WIDTH)) u_wb_drain (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (switch_banks),
        .ofmap_size(n_cfg),
        .wb_ready  (wb_ready),
        .ren_wb    (ren_wb),
        .radr_wb   (radr_wb),
        .wb_valid  (wb_valid),
        .wb_done   (wb_done)
    );
`ifdef ACCUM_BUF_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_switch_cycles <= '0;
            stall_wb_cycles     <= '0;
        end else begin
            if (state == WAIT_SWITCH && !wb_done && !(&stall_switch_cycles))
                stall_switch_cycles <= stall_switch_cycles + 1'b1;
            if (wb_valid && !wb_ready && !(&stall_wb_cycles))
                stall_wb_cycles <= stall_wb_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_accumulation_buffer_ctrl.sv
// tb_accumulation_buffer_ctrl: randomized and directed checks of the accumulation buffer sequencer against a beat/word-count model
module tb_accumulation_buffer_ctrl;
    localparam int AW = 9;
    localparam int CW = 16;
    logic clk = 1'b0, rst_n = 1'b0, config_en = 1'b0, acc_valid = 1'b0, wb_ready = 1'b0;
    logic [AW-1:0] config_ofmap_size = '0;
    logic [CW-1:0] config_num_passes = '0;
    logic acc_ready, acc_first, ren, wen, ren_wb, wb_valid, switch_banks, tile_done;
    logic [AW-1:0] radr, wadr, radr_wb;
`ifdef ACCUM_BUF_CTRL_PERF_EN
    logic [31:0] stall_switch_cycles, stall_wb_cycles;
`endif
    always #5 clk = ~clk;

    accumulation_buffer_ctrl #(.BANK_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .config_en(config_en),
        .config_ofmap_size(config_ofmap_size), .config_num_passes(config_num_passes),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_first(acc_first),
        .ren(ren), .radr(radr), .wen(wen), .wadr(wadr),
        .ren_wb(ren_wb), .radr_wb(radr_wb), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .switch_banks(switch_banks), .tile_done(tile_done)
`ifdef ACCUM_BUF_CTRL_PERF_EN
        , .stall_switch_cycles(stall_switch_cycles), .stall_wb_cycles(stall_wb_cycles)
`endif
    );

    int n_cmp = 0, n_err = 0;
    // model: tile progress as beat count, drain as a queue of issued-but-unconsumed words
    bit cfgd, pb, pf, dact, drained;
    int n, p, beats, padr, rd, outc, ssw, swb, obs_first, obs_beats;
    int q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        cfgd = 0; pb = 0; pf = 0; dact = 0; drained = 1;
        n = 0; p = 0; beats = 0; padr = 0; rd = 0; outc = 0; ssw = 0; swb = 0;
        q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_acc_ready"}, 32'(acc_ready), 0);
        chk({tag, "_acc_first"}, 32'(acc_first), 0);
        chk({tag, "_ren"}, 32'(ren), 0);
        chk({tag, "_radr"}, 32'(radr), 0);
        chk({tag, "_wen"}, 32'(wen), 0);
        chk({tag, "_wadr"}, 32'(wadr), 0);
        chk({tag, "_ren_wb"}, 32'(ren_wb), 0);
        chk({tag, "_radr_wb"}, 32'(radr_wb), 0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 0);
        chk({tag, "_switch"}, 32'(switch_banks), 0);
        chk({tag, "_tile_done"}, 32'(tile_done), 0);
`ifdef ACCUM_BUF_CTRL_PERF_EN
        chk({tag, "_stall_sw"}, stall_switch_cycles, 0);
        chk({tag, "_stall_wb"}, stall_wb_cycles, 0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        acc_valid = 1'b0; config_en = 1'b0; wb_ready = 1'b0;
        #1;
        check_zero("reset");
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic cyc(input bit av, input bit wr, input bit ce, input int cn, input int cp);
        bit er, eren, esw, erwb, evld;
        int eradr;
        acc_valid = av; wb_ready = wr; config_en = ce;
        config_ofmap_size = AW'(cn); config_num_passes = CW'(cp);
        @(negedge clk);
        er    = cfgd && beats < n * p;
        eren  = av && er;
        eradr = (eren && n > 0) ? beats % n : 0;
        esw   = cfgd && beats == n * p && drained;
        evld  = q.size() > 0;
        erwb  = dact && rd < n && (!evld || wr);
        chk("acc_ready", 32'(acc_ready), 32'(er));
        chk("ren", 32'(ren), 32'(eren));
        chk("radr", 32'(radr), 32'(eradr));
        chk("wen", 32'(wen), 32'(pb));
        if (pb) chk("wadr", 32'(wadr), 32'(padr));
        chk("acc_first", 32'(acc_first), 32'(pb && pf));
        chk("switch_banks", 32'(switch_banks), 32'(esw));
        chk("tile_done", 32'(tile_done), 32'(esw));
        chk("ren_wb", 32'(ren_wb), 32'(erwb));
        chk("radr_wb", 32'(radr_wb), 32'(erwb ? rd : 0));
        chk("wb_valid", 32'(wb_valid), 32'(evld));
`ifdef ACCUM_BUF_CTRL_PERF_EN
        chk("stall_switch_cycles", stall_switch_cycles, 32'(ssw));
        chk("stall_wb_cycles", stall_wb_cycles, 32'(swb));
`endif
        if (acc_first) obs_first++;
        if (ren) obs_beats++;
        if (cfgd && beats == n * p && !drained) ssw++;
        if (evld && !wr) swb++;
        pb = eren;
        padr = eradr;
        pf = n > 0 && beats < n;
        if (eren) beats++;
        if (evld && wr) begin
            void'(q.pop_front());
            outc++;
            if (outc == n) begin drained = 1; dact = 0; end
        end
        if (erwb) begin q.push_back(rd); rd++; end
        if (esw) begin beats = 0; dact = 1; rd = 0; outc = 0; drained = 0; end
        if (!cfgd && ce) begin cfgd = 1; n = cn; p = cp; end
        @(posedge clk); #1;
    endtask

    initial begin
        m_reset();
        #12;
        check_zero("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        // N=4, P=1 with acc_valid held high, then a full-rate drain
        cyc(0, 0, 1, 4, 1);
        repeat (5) cyc(1, 1, 0, 0, 0);
        repeat (6) cyc(0, 1, 0, 0, 0);
        // second tile, then a drain stalled 5 cycles on word 1 while the third tile completes
        repeat (5) cyc(1, 1, 0, 0, 0);
        repeat (2) cyc(1, 1, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 0, 0);
`ifdef ACCUM_BUF_CTRL_PERF_EN
        chk("stall_wb_5", stall_wb_cycles, 5);
`endif
        repeat (6) cyc(1, 1, 0, 0, 0);
        // config outside IDLE must be ignored
        repeat (3) cyc(1, 1, 1, 7, 2);
        for (int i = 0; i < 200; i++) cyc(1'($urandom), ($urandom % 4) != 0, 0, 0, 0);
        // reset while word 2 of a drain is outstanding
        for (int i = 0; i < 100 && !(dact && rd == 3); i++) cyc(1, 1, 0, 0, 0);
        chk("mid_drain_reached", 32'(dact && rd == 3), 1);
        do_reset();
        // N=4, P=3 with acc_valid toggling
        cyc(0, 1, 1, 4, 3);
        obs_first = 0; obs_beats = 0;
        for (int i = 0; i < 24; i++) cyc(i % 2 == 0, 1, 0, 0, 0);
        chk("p3_first_writes", 32'(obs_first), 4);
        chk("p3_beats", 32'(obs_beats), 12);
        for (int i = 0; i < 100; i++) cyc(1'($urandom), 1'($urandom), 0, 0, 0);
        // random geometries
        for (int k = 0; k < 3; k++) begin
            do_reset();
            cyc(0, 0, 1, $urandom_range(2, 8), $urandom_range(1, 3));
            for (int i = 0; i < 300; i++) cyc(($urandom % 3) != 0, ($urandom % 3) != 0, 0, 0, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/accumulation_buffer_ctrl.md
Name: accumulation_buffer_ctrl

Overview:
- Sequencer for the double-banked accumulation buffer.
- Generates the read-modify-write address stream on the accumulation side (ren/radr, then wen/wadr one cycle later).
- Drains the writeback bank to a valid/ready consumer (ren_wb/radr_wb).
- Issues the one-cycle switch_banks pulse when the accumulation of a tile is complete and the previous tile is fully drained.

Parameters:
- BANK_ADDR_WIDTH, 9, address width of one bank.
- COUNT_WIDTH, 16, width of the pass counter and the config pass count.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- config_en  input  1  latch config; honoured only in IDLE
- config_ofmap_size  input  BANK_ADDR_WIDTH  words per tile (N), N>=1
- config_num_passes  input  COUNT_WIDTH  accumulation passes per tile (P), P>=1
- acc_valid  input  1  MAC result available this cycle
- acc_ready  output  1  controller accepts acc_valid
- acc_first  output  1  current write is pass 0; adder must use 0 instead of rdata
- ren  output  1  accumulation-bank read enable
- radr  output  BANK_ADDR_WIDTH  accumulation-bank read address
- wen  output  1  accumulation-bank write enable
- wadr  output  BANK_ADDR_WIDTH  accumulation-bank write address
- ren_wb  output  1  writeback-bank read enable
- radr_wb  output  BANK_ADDR_WIDTH  writeback-bank read address
- wb_valid  output  1  rdata_wb holds a word for the consumer
- wb_ready  input  1  consumer accepts the word
- switch_banks  output  1  one-cycle bank swap pulse
- tile_done  output  1  one-cycle pulse, coincident with switch_banks

Behaviour:
- Reset: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs are 0 during and after reset. Both FSMs go to IDLE/WB_IDLE; all counters are 0; wb_done=1.
- Accumulation FSM: IDLE -> ACCUM on config_en. ACCUM -> WAIT_SWITCH when the last word of pass P-1 is accepted. WAIT_SWITCH -> ACCUM on switch_banks.
- acc_ready=1 only in ACCUM. An accepted beat (acc_valid&&acc_ready) drives ren=1 and radr=adr in that cycle.
- One cycle later: wen=1, wadr=previous radr, acc_first=(pass of that beat==0). Fixed RMW latency is 1.
- adr wraps N-1 -> 0 with pass+1. After the beat at adr=N-1 in pass P-1, the FSM enters WAIT_SWITCH with acc_ready=0.
- Because the write trails the read by one cycle, back-to-back beats never read an address still awaiting write. Exception: N=1 with consecutive beats hits the same address, which needs an external bypass and is out of scope. Bench uses N>=2.
- Switch: switch_banks=1 for exactly one cycle when FSM==WAIT_SWITCH && wb_done.
  - May coincide with the final trailing wen, which lands in the old bank.
  - Same edge: adr=0, pass=0, FSM->ACCUM, wb FSM->WB_DRAIN with wb_adr=0, wb_done=0.
- Writeback FSM WB_DRAIN:
  - ren_wb=1, radr_wb=wb_adr whenever !wb_valid || wb_ready; wb_adr increments.
  - wb_valid is set the cycle after ren_wb. It holds, with rdata_wb stable, until wb_ready. It clears on handshake unless a new read issues in the same cycle.
  - Full throughput is 1 word/cycle with wb_ready held high.
  - After the read of N-1 is issued, no more reads. wb_done=1 and FSM->WB_IDLE on the handshake of word N-1.
- config_en outside IDLE is ignored. Config is latched only in IDLE. Returning to IDLE requires reset.
- Reset mid-tile: all state is abandoned. Buffer contents are undefined to the controller.

Optional Feature:
- Macro ACCUM_BUF_CTRL_PERF_EN.
- Defined: adds outputs stall_switch_cycles[31:0] and stall_wb_cycles[31:0].
  - stall_switch_cycles counts cycles in WAIT_SWITCH with !wb_done.
  - stall_wb_cycles counts cycles with wb_valid&&!wb_ready.
  - Both saturate and reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state enums (acc_state_t: IDLE/ACCUM/WAIT_SWITCH; wb_state_t: WB_IDLE/WB_DRAIN) and the RMW latency constant ACC_RMW_LATENCY=1.
- One natural sub-module: accumulation_buffer_wb_drain, containing the writeback counter, the valid/ready hold and wb_done.

Test Plan:
- N=4, P=1, acc_valid held high: ren at adr 0,1,2,3 on consecutive cycles; wen at 0..3 one cycle later with acc_first=1; switch_banks pulses the cycle of wen adr 3; tile_done coincident.
- N=4, P=3, acc_valid toggling 1/0: 12 accepted beats; acc_first=1 only for the first 4 writes; acc_ready=0 after beat 12.
- After the first switch, wb_ready=1: ren_wb at radr_wb 0..3 consecutive; wb_valid high 4 cycles starting one cycle after the first ren_wb; wb_done after word 3.
- wb_ready low for 5 cycles on word 1: wb_valid held and no new ren_wb; drain resumes word 2; stall_wb_cycles=5 with ACCUM_BUF_CTRL_PERF_EN.
- Second tile finishes accumulation while the drain is stalled: acc_ready=0, no switch_banks until the word-3 handshake, then switch_banks pulses the next cycle.
- rst_n asserted mid-drain at word 2: all outputs 0 immediately (async); config_en during ACCUM ignored (N stays 4).
